// File: rtl/main_road_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// main_road_ctrl_pkg
// Purpose : Shared definitions for the main road controller, the pedestrian
//           light block and the top level. It holds the state encodings, the
//           default timing constants in ticks, and a small helper that detects
//           the Nth tick in a state.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package main_road_ctrl_pkg;

    typedef enum logic [2:0] {
        S_GREEN  = 3'b000,
        S_YELLOW = 3'b001,
        S_ALLRED = 3'b010,
        S_PED    = 3'b011,
        S_CLEAR  = 3'b100
    } state_t;

    localparam int          CNT_W           = 4;
    localparam logic [3:0]  CNT_MAX         = 4'd15;

    localparam logic [3:0]  DEF_MIN_GREEN   = 4'd6;
    localparam logic [3:0]  DEF_YELLOW_TIME = 4'd2;
    localparam logic [3:0]  DEF_ALLRED_TIME = 4'd1;
    localparam logic [3:0]  DEF_MAX_WALK    = 4'd5;

    // The Nth tick in a state arrives while the counter still holds N-1,
    // because the counter has only seen the earlier ticks.
    function automatic logic nth_tick(input logic       tick,
                                      input logic [3:0] count,
                                      input logic [3:0] n);
        return tick && (count == (n - 4'd1));
    endfunction

endpackage

// File: rtl/main_road_ctrl_if.sv
// -----------------------------------------------------------------------------
// main_road_ctrl_if
// Purpose : Groups the time base, the pedestrian request/grant/done handshake
//           and the main road lamp outputs into one bundle.
// Signals : tick, ped_req, ped_done      -> into the controller
//           R1, Y1, G1, ped_grant,
//           ped_wait, present_state      <- out of the controller
// Modports: master - the main road controller
//           slave  - the pedestrian side or the environment
// -----------------------------------------------------------------------------
interface main_road_ctrl_if;
    logic       tick;
    logic       ped_req;
    logic       ped_done;
    logic       R1;
    logic       Y1;
    logic       G1;
    logic       ped_grant;
    logic       ped_wait;
    logic [2:0] present_state;

    modport master (
        input  tick, ped_req, ped_done,
        output R1, Y1, G1, ped_grant, ped_wait, present_state
    );

    modport slave (
        output tick, ped_req, ped_done,
        input  R1, Y1, G1, ped_grant, ped_wait, present_state
    );
endinterface

// File: rtl/main_road_ctrl_tick_timer.sv
// -----------------------------------------------------------------------------
// main_road_ctrl_tick_timer
// Purpose : 4-bit tick counter that saturates at 15 and has a synchronous
//           clear. A clear on the same cycle as a tick wins, so a new state
//           always starts counting from zero.
// Ports   : clk     - system clock
//           rst     - asynchronous active-high reset
//           i_clear - synchronous clear to 0
//           i_tick  - one-cycle time-base pulse
//           o_count - current count
// -----------------------------------------------------------------------------
module main_road_ctrl_tick_timer
    import main_road_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_tick,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick && (r_count != CNT_MAX)) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/main_road_ctrl.sv
// -----------------------------------------------------------------------------
// main_road_ctrl
// Purpose : Main road signal controller. It runs G1 -> Y1 -> R1, hands the
//           crossing to the pedestrian block through the ped_req/ped_grant/
//           ped_done handshake, and returns to green after an all-red
//           clearance.
// Ports   : clk   - system clock
//           reset - asynchronous active-high reset
//           bus   - main_road_ctrl_if.master (tick, ped_req, ped_done in;
//                   R1, Y1, G1, ped_grant, ped_wait, present_state out)
// -----------------------------------------------------------------------------
module main_road_ctrl
    import main_road_ctrl_pkg::*;
#(
    parameter logic [3:0] MIN_GREEN   = DEF_MIN_GREEN,
    parameter logic [3:0] YELLOW_TIME = DEF_YELLOW_TIME,
    parameter logic [3:0] ALLRED_TIME = DEF_ALLRED_TIME,
    parameter logic [3:0] MAX_WALK    = DEF_MAX_WALK
)
(
    input  logic             clk,
    input  logic             reset,
    main_road_ctrl_if.master bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] w_count;
    logic             w_state_change;

    logic r_req_latch, w_req_next;
    logic r_r1, r_y1, r_g1, r_grant;
    logic w_r1_next, w_y1_next, w_g1_next, w_grant_next;

    // The timer restarts at every state change.
    main_road_ctrl_tick_timer u_tick_timer (
        .clk     (clk),
        .rst     (reset),
        .i_clear (w_state_change),
        .i_tick  (bus.tick),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_GREEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The lamps are decoded from the next state and then registered.
    // They change on the same edge as present_state, and no input
    // has a combinational path to an output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_latch <= 1'b0;
            r_r1        <= 1'b0;
            r_y1        <= 1'b0;
            r_g1        <= 1'b1;
            r_grant     <= 1'b0;
        end else begin
            r_req_latch <= w_req_next;
            r_r1        <= w_r1_next;
            r_y1        <= w_y1_next;
            r_g1        <= w_g1_next;
            r_grant     <= w_grant_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req_latch;
        w_r1_next    = 1'b0;
        w_y1_next    = 1'b0;
        w_g1_next    = 1'b0;
        w_grant_next = 1'b0;

        case (r_state)
            S_GREEN: begin
                // A request seen on this cycle counts, so a request that
                // arrives once the minimum green has passed is served at once.
                if ((r_req_latch || bus.ped_req) && (w_count >= MIN_GREEN))
                    w_state_next = S_YELLOW;
            end
            S_YELLOW: begin
                if (nth_tick(bus.tick, w_count, YELLOW_TIME))
                    w_state_next = S_ALLRED;
            end
            S_ALLRED: begin
                if (nth_tick(bus.tick, w_count, ALLRED_TIME))
                    w_state_next = S_PED;
            end
            S_PED: begin
                if (bus.ped_done || nth_tick(bus.tick, w_count, MAX_WALK))
                    w_state_next = S_CLEAR;
            end
            S_CLEAR: begin
                if (nth_tick(bus.tick, w_count, ALLRED_TIME))
                    w_state_next = S_GREEN;
            end
            default: w_state_next = S_GREEN;
        endcase

        w_state_change = (w_state_next != r_state);

        // The request is served when the crossing is granted. A request seen
        // during the crossing itself is dropped. A request seen during
        // clearance is held for the next cycle of the sequence.
        if ((w_state_next == S_PED) && (r_state != S_PED))
            w_req_next = 1'b0;
        else if (bus.ped_req && (r_state != S_PED))
            w_req_next = 1'b1;

        case (w_state_next)
            S_GREEN:          w_g1_next = 1'b1;
            S_YELLOW:         w_y1_next = 1'b1;
            S_ALLRED,
            S_CLEAR:          w_r1_next = 1'b1;
            S_PED: begin
                w_r1_next    = 1'b1;
                w_grant_next = 1'b1;
            end
            default:          w_g1_next = 1'b1;
        endcase
    end

    assign bus.R1            = r_r1;
    assign bus.Y1            = r_y1;
    assign bus.G1            = r_g1;
    assign bus.ped_grant     = r_grant;
    assign bus.ped_wait      = r_req_latch;
    assign bus.present_state = r_state;

endmodule

// File: tb/tb_main_road_ctrl.sv
// -----------------------------------------------------------------------------
// tb_main_road_ctrl
// Purpose : Self-checking bench for main_road_ctrl. A phase-level reference
//           model holds the current phase, the ticks spent in that phase and a
//           pending-request flag. Every cycle the bench compares the DUT
//           outputs with the model. The stimulus mixes directed sequences with
//           random ticks, requests, done pulses and asynchronous resets.
// -----------------------------------------------------------------------------
module tb_main_road_ctrl;

    localparam int MIN_GREEN   = 6;
    localparam int YELLOW_TIME = 2;
    localparam int ALLRED_TIME = 1;
    localparam int MAX_WALK    = 5;

    // Model phases in the order the sequence visits them.
    localparam int M_GREEN  = 0;
    localparam int M_YELLOW = 1;
    localparam int M_ALLRED = 2;
    localparam int M_PED    = 3;
    localparam int M_CLEAR  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    main_road_ctrl_if bus ();

    main_road_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_phase;
    int m_ticks;      // ticks seen in the current phase
    bit m_pending;    // a request is waiting to be served
    int dwell [5] = '{0, YELLOW_TIME, ALLRED_TIME, MAX_WALK, ALLRED_TIME};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] phase_code(input int p);
        case (p)
            M_GREEN:  return 3'b000;
            M_YELLOW: return 3'b001;
            M_ALLRED: return 3'b010;
            M_PED:    return 3'b011;
            default:  return 3'b100;
        endcase
    endfunction

    task automatic model_reset();
        m_phase   = M_GREEN;
        m_ticks   = 0;
        m_pending = 1'b0;
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_step(input bit t, input bit r, input bit d);
        bit leave;
        int nxt;
        if (m_phase == M_GREEN)
            leave = (m_pending || r) && (m_ticks >= MIN_GREEN);
        else
            leave = (t && (m_ticks + 1 == dwell[m_phase])) ||
                    (m_phase == M_PED && d);
        nxt = leave ? (m_phase + 1) % 5 : m_phase;
        if (nxt == M_PED && m_phase != M_PED)
            m_pending = 1'b0;
        else if (r && m_phase != M_PED)
            m_pending = 1'b1;
        m_ticks = leave ? 0 : m_ticks + int'(t);
        m_phase = nxt;
    endtask

    task automatic check_outputs(input string where);
        check({where, "/state"}, bus.present_state, phase_code(m_phase));
        check({where, "/G1"}, bus.G1, m_phase == M_GREEN);
        check({where, "/Y1"}, bus.Y1, m_phase == M_YELLOW);
        check({where, "/R1"}, bus.R1, m_phase >= M_ALLRED);
        check({where, "/grant"}, bus.ped_grant, m_phase == M_PED);
        check({where, "/wait"}, bus.ped_wait, m_pending);
        check({where, "/onehot"}, $countones({bus.R1, bus.Y1, bus.G1}), 1);
    endtask

    // Called just after a falling edge. Inputs are applied for the next
    // rising edge, and the outputs are checked at the following falling edge.
    task automatic drive(input bit t, input bit r, input bit d, input string where);
        bus.tick     = t;
        bus.ped_req  = r;
        bus.ped_done = d;
        model_step(t, r, d);
        @(negedge clk);
        check_outputs(where);
    endtask

    // Assert reset between clock edges and check that the outputs respond
    // before any edge arrives.
    task automatic async_reset(input string where);
        #2 reset = 1'b1;
        model_reset();
        #1 check_outputs(where);
        #1 reset = 1'b0;
    endtask

    // Serve one request. The request pulses after two ticks. done_after < 0
    // means ped_done never arrives. When req_in_ped is set, ped_req is held
    // during the crossing and the clearance.
    task automatic serve(input int done_after, input bit req_in_ped, input string where);
        bit seen_ped = 1'b0;
        bit done_ok  = 1'b0;
        async_reset({where, "_rst"});
        drive(1, 0, 0, where);
        drive(0, 0, 0, where);
        drive(1, 0, 0, where);
        drive(0, 1, 0, where);
        for (int g = 0; g < 400; g++) begin
            bit t, r, d;
            t = (g % 2 == 0);
            d = (m_phase == M_PED) && (done_after >= 0) && (m_ticks >= done_after);
            r = req_in_ped && (m_phase == M_PED || m_phase == M_CLEAR);
            drive(t, r, d, where);
            if (m_phase == M_PED) seen_ped = 1'b1;
            if (seen_ped && m_phase == M_GREEN) begin
                done_ok = 1'b1;
                break;
            end
        end
        check({where, "/completed"}, done_ok, 1'b1);
    endtask

    task automatic run_until(input int phase, input string where);
        bit hit = 1'b0;
        for (int g = 0; g < 400; g++) begin
            drive($urandom_range(0, 1) == 0, 1, 0, where);
            if (m_phase == phase) begin
                hit = 1'b1;
                break;
            end
        end
        check({where, "/reached"}, hit, 1'b1);
    endtask

    initial begin
        bus.tick     = 1'b0;
        bus.ped_req  = 1'b0;
        bus.ped_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        reset = 1'b0;

        // Green holds with no request.
        for (int i = 0; i < 120; i++) drive(i % 3 == 2, 0, 0, "idle");

        // Crossing ended by ped_done, by timeout, and with requests during it.
        serve(2, 1'b0, "done2");
        serve(-1, 1'b0, "timeout");
        serve(2, 1'b1, "req_in_ped");
        for (int i = 0; i < 60; i++) drive(i % 2 == 0, 0, 0, "after_clear");

        // Asynchronous reset in yellow and during the crossing.
        run_until(M_YELLOW, "to_yellow");
        async_reset("rst_yellow");
        run_until(M_PED, "to_ped");
        drive(1, 0, 0, "in_ped");
        async_reset("rst_ped");

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) == 0, "rand");
            if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
